// File: rtl/tuple_pkt_arbiter_pkg.sv
// Shared widths and FSM encoding for the two-port tuple packet arbiter.
package tarb_pkg;
  localparam int DATA_W  = 256;
  localparam int KEEP_W  = DATA_W / 8;
  localparam int TUPLE_W = 128;

  typedef enum logic [1:0] {
    ST_IDLE = 2'b00,
    ST_XFER = 2'b01
  } state_t;
endpackage

// File: rtl/tuple_pkt_arbiter_if.sv
// AXIS-style bundle: two packet/tuple sources in, one tuple-tagged stream out.
// Handshake: a beat moves on a rising edge where valid and ready are both high;
// valid never depends on ready, and a stalled beat holds its payload until taken.
interface tuple_pkt_arbiter_if;
  import tarb_pkg::*;

  logic               s0_avalid, s1_avalid;
  logic               s0_aready, s1_aready;
  logic [DATA_W-1:0]  s0_adata,  s1_adata;
  logic [KEEP_W-1:0]  s0_akeep,  s1_akeep;
  logic               s0_atlast, s1_atlast;
  logic               s0_tvalid, s1_tvalid;
  logic [TUPLE_W-1:0] s0_tdata,  s1_tdata;
  logic               m_bvalid,  m_bready;
  logic [DATA_W-1:0]  m_bdata;
  logic [KEEP_W-1:0]  m_bkeep;
  logic               m_btlast;
  logic [TUPLE_W-1:0] m_btuser;

  // master: the surrounding system (sources and sink); slave: the arbiter.
  modport master (
    output s0_avalid, s0_adata, s0_akeep, s0_atlast, s0_tvalid, s0_tdata,
    output s1_avalid, s1_adata, s1_akeep, s1_atlast, s1_tvalid, s1_tdata,
    output m_bready,
    input  s0_aready, s1_aready, m_bvalid, m_bdata, m_bkeep, m_btlast, m_btuser
  );
  modport slave (
    input  s0_avalid, s0_adata, s0_akeep, s0_atlast, s0_tvalid, s0_tdata,
    input  s1_avalid, s1_adata, s1_akeep, s1_atlast, s1_tvalid, s1_tdata,
    input  m_bready,
    output s0_aready, s1_aready, m_bvalid, m_bdata, m_bkeep, m_btlast, m_btuser
  );
endinterface

// File: rtl/tuple_pkt_arbiter_tuple_slot.sv
// One-deep tuple holder per source: captures a tuple, flags a pending packet,
// and records a sticky overflow when a tuple arrives while the slot is busy.
module tuple_slot
  import tarb_pkg::*;
(
  input  logic               clk,
  input  logic               rst_n,
  input  logic               tvalid,
  input  logic [TUPLE_W-1:0] tdata,
  input  logic               clr,
  output logic [TUPLE_W-1:0] tuple,
  output logic               pend,
  output logic               ovf
);
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      tuple <= '0;
      pend  <= 1'b0;
      ovf   <= 1'b0;
    end else if (tvalid) begin
      // A slot being freed this cycle may take the new tuple without overflow.
      if (!pend || clr) begin
        tuple <= tdata;
        pend  <= 1'b1;
      end else begin
        ovf <= 1'b1;
      end
    end else if (clr) begin
      pend <= 1'b0;
    end
  end
endmodule

// File: rtl/tuple_pkt_arbiter.sv
// Round-robin whole-packet arbiter sharing one tuple-tagged output stream
// between two sources; a packet is only granted once its tuple is held.
module tuple_pkt_arbiter
  import tarb_pkg::*;
#(
  parameter int CNT_W = 32
) (
  input  logic                tarb_aclk,
  input  logic                tarb_arst,
  tuple_pkt_arbiter_if.slave  bus,
  output logic [CNT_W-1:0]    pkt_cnt0,
  output logic [CNT_W-1:0]    pkt_cnt1,
  output logic [1:0]          tup_ovf,
  output logic [1:0]          dbg_state
);
  localparam logic [CNT_W-1:0] CNT_ONE = CNT_W'(1);

  state_t             state;
  logic               grant;
  logic               last_grant;
  logic [1:0]         pend;
  logic [1:0]         req;
  logic [1:0]         clr;
  logic [TUPLE_W-1:0] tuple0, tuple1;
  logic               xfer;
  logic               eop;
  logic               sel_valid;
  logic [DATA_W-1:0]  sel_data;
  logic [KEEP_W-1:0]  sel_keep;
  logic               sel_last;
  logic [TUPLE_W-1:0] sel_tuple;

  tuple_slot u_slot0 (
    .clk(tarb_aclk), .rst_n(tarb_arst), .tvalid(bus.s0_tvalid), .tdata(bus.s0_tdata),
    .clr(clr[0]), .tuple(tuple0), .pend(pend[0]), .ovf(tup_ovf[0])
  );
  tuple_slot u_slot1 (
    .clk(tarb_aclk), .rst_n(tarb_arst), .tvalid(bus.s1_tvalid), .tdata(bus.s1_tdata),
    .clr(clr[1]), .tuple(tuple1), .pend(pend[1]), .ovf(tup_ovf[1])
  );

  assign req       = {bus.s1_avalid & pend[1], bus.s0_avalid & pend[0]};
  assign xfer      = (state == ST_XFER);
  assign dbg_state = state;

  // Output path is a pure mux of the granted source; everything is zero outside XFER.
  always_comb begin
    sel_valid     = 1'b0;
    sel_data      = '0;
    sel_keep      = '0;
    sel_last      = 1'b0;
    sel_tuple     = '0;
    bus.s0_aready = 1'b0;
    bus.s1_aready = 1'b0;
    if (xfer) begin
      if (grant) begin
        sel_valid     = bus.s1_avalid;
        sel_data      = bus.s1_adata;
        sel_keep      = bus.s1_akeep;
        sel_last      = bus.s1_atlast;
        sel_tuple     = tuple1;
        bus.s1_aready = bus.m_bready;
      end else begin
        sel_valid     = bus.s0_avalid;
        sel_data      = bus.s0_adata;
        sel_keep      = bus.s0_akeep;
        sel_last      = bus.s0_atlast;
        sel_tuple     = tuple0;
        bus.s0_aready = bus.m_bready;
      end
    end
  end

  assign bus.m_bvalid = sel_valid;
  assign bus.m_bdata  = sel_data;
  assign bus.m_bkeep  = sel_keep;
  assign bus.m_btlast = sel_last;
  assign bus.m_btuser = sel_tuple;

  assign eop = sel_valid & bus.m_bready & sel_last;
  assign clr = {eop & grant, eop & ~grant};

  always_ff @(posedge tarb_aclk or negedge tarb_arst) begin
    if (!tarb_arst) begin
      state      <= ST_IDLE;
      grant      <= 1'b0;
      last_grant <= 1'b1;
      pkt_cnt0   <= '0;
      pkt_cnt1   <= '0;
    end else begin
      case (state)
        ST_IDLE: begin
          if (|req) begin
            // On a tie the port that did not go last wins.
            grant <= (&req) ? ~last_grant : req[1];
            state <= ST_XFER;
          end
        end
        ST_XFER: begin
          if (eop) begin
            last_grant <= grant;
            if (grant) pkt_cnt1 <= pkt_cnt1 + CNT_ONE;
            else       pkt_cnt0 <= pkt_cnt0 + CNT_ONE;
            state <= ST_IDLE;
          end
        end
        default: state <= ST_IDLE;
      endcase
    end
  end
endmodule

// File: tb/tb_tuple_pkt_arbiter.sv
// Directed bench for tuple_pkt_arbiter: expected beats are queued as stimulus
// is issued and checked in order as the output stream hands them over.
module tb_tuple_pkt_arbiter;
  import tarb_pkg::*;

  localparam int CNT_W = 4;
  localparam int BW    = TUPLE_W + 1 + KEEP_W + DATA_W;

  logic             clk   = 1'b0;
  logic             rst_n = 1'b0;
  logic [CNT_W-1:0] pkt_cnt0, pkt_cnt1;
  logic [1:0]       tup_ovf, dbg_state;

  logic [BW-1:0]    exp_q[$];
  int               n_cmp  = 0;
  int               n_fail = 0;
  int               cyc    = 0;
  logic [CNT_W-1:0] exp_cnt0, exp_cnt1;
  logic             prev_stall = 1'b0;
  logic [BW-1:0]    prev_beat, cur_beat;

  tuple_pkt_arbiter_if bus ();

  tuple_pkt_arbiter #(.CNT_W(CNT_W)) dut (
    .tarb_aclk (clk),
    .tarb_arst (rst_n),
    .bus       (bus),
    .pkt_cnt0  (pkt_cnt0),
    .pkt_cnt1  (pkt_cnt1),
    .tup_ovf   (tup_ovf),
    .dbg_state (dbg_state)
  );

  // ---------------- clock / reset ----------------
  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  // ---------------- checking helpers ----------------
  task automatic chk_b(input string tag, input logic [BW-1:0] obs, input logic [BW-1:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic chk_i(input string tag, input int obs, input int exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
    end
  endtask

  function automatic logic [DATA_W-1:0] mk_data(input logic [31:0] s, input int b);
    return {8{s ^ 32'(b)}};
  endfunction

  function automatic logic [KEEP_W-1:0] mk_keep(input logic [31:0] s, input int b);
    return ~s ^ 32'(b * 7);
  endfunction

  function automatic logic [TUPLE_W-1:0] mk_tuple(input logic [31:0] s);
    return {4{s}};
  endfunction

  function automatic logic [BW-1:0] mk_beat(input logic [TUPLE_W-1:0] t, input logic [31:0] s,
                                            input int b, input int n);
    return {t, (b == n - 1), mk_keep(s, b), mk_data(s, b)};
  endfunction

  task automatic push_pkt(input logic [TUPLE_W-1:0] t, input logic [31:0] s, input int n);
    for (int b = 0; b < n; b++) exp_q.push_back(mk_beat(t, s, b, n));
  endtask

  // ---------------- driver tasks ----------------
  task automatic set_beat(input int p, input logic v, input logic [DATA_W-1:0] d,
                          input logic [KEEP_W-1:0] k, input logic l);
    if (p == 0) begin
      bus.s0_avalid = v; bus.s0_adata = d; bus.s0_akeep = k; bus.s0_atlast = l;
    end else begin
      bus.s1_avalid = v; bus.s1_adata = d; bus.s1_akeep = k; bus.s1_atlast = l;
    end
  endtask

  task automatic set_tup(input int p, input logic v, input logic [TUPLE_W-1:0] t);
    if (p == 0) begin
      bus.s0_tvalid = v; bus.s0_tdata = t;
    end else begin
      bus.s1_tvalid = v; bus.s1_tdata = t;
    end
  endtask

  function automatic logic get_ready(input int p);
    return (p == 0) ? bus.s0_aready : bus.s1_aready;
  endfunction

  // Called just after a rising edge; leaves just after the edge that captured the tuple.
  task automatic pulse_tuple(input int p, input logic [TUPLE_W-1:0] t);
    set_tup(p, 1'b1, t);
    @(posedge clk); #1;
    set_tup(p, 1'b0, '0);
  endtask

  // Offers n beats, counting cycles the source was held off; optionally strobes
  // a new tuple on the same edge as the last-beat handshake.
  task automatic send_pkt(input int p, input int n, input logic [31:0] s,
                          input logic tup_on_last, input logic [TUPLE_W-1:0] late_t,
                          output int stalls);
    int   b      = 0;
    int   budget = 200;
    logic tset;
    stalls = 0;
    while (b < n) begin
      tset = 1'b0;
      set_beat(p, 1'b1, mk_data(s, b), mk_keep(s, b), (b == n - 1));
      @(negedge clk);
      if (get_ready(p)) begin
        if (tup_on_last && b == n - 1) begin
          set_tup(p, 1'b1, late_t);
          tset = 1'b1;
        end
        b++;
      end else begin
        stalls++;
        budget--;
        if (budget == 0) begin
          n_cmp++;
          n_fail++;
          $error("FAIL send_timeout: port %0d stuck at beat %0d of %0d", p, b, n);
          break;
        end
      end
      @(posedge clk); #1;
      if (tset) set_tup(p, 1'b0, '0);
    end
    set_beat(p, 1'b0, '0, '0, 1'b0);
  endtask

  task automatic do_reset();
    rst_n = 1'b0;
    set_beat(0, 1'b0, '0, '0, 1'b0);
    set_beat(1, 1'b0, '0, '0, 1'b0);
    set_tup(0, 1'b0, '0);
    set_tup(1, 1'b0, '0);
    bus.m_bready = 1'b1;
    exp_q.delete();
    exp_cnt0 = '0;
    exp_cnt1 = '0;
    repeat (2) @(posedge clk);
    #1 rst_n = 1'b1;
    @(posedge clk); #1;
  endtask

  // ---------------- stimulus, scoreboard and report ----------------
  initial begin
    int               st, st0, st1, t_start, t_end;
    logic [31:0]      s, sa0, sa1, sb0, sb1, s5;
    logic [TUPLE_W-1:0] t, t2, ta0, ta1, tb0, tb1, t5;

    // Output monitor: pops one expected beat per handshake, checks stall stability.
    fork
      forever begin
        @(negedge clk);
        if (rst_n) begin
          cur_beat = {bus.m_btuser, bus.m_btlast, bus.m_bkeep, bus.m_bdata};
          if (prev_stall && bus.m_bvalid) chk_b("stall_stable", cur_beat, prev_beat);
          if (bus.m_bvalid && bus.m_bready) begin
            if (exp_q.size() == 0) begin
              n_cmp++;
              n_fail++;
              $error("FAIL unexpected_beat: observed %0h expected none", cur_beat);
            end else begin
              chk_b("beat", cur_beat, exp_q.pop_front());
            end
          end
          prev_stall = bus.m_bvalid && !bus.m_bready;
          prev_beat  = cur_beat;
        end else begin
          prev_stall = 1'b0;
        end
      end
    join_none

    // Reset state, checked while held and after release.
    set_beat(0, 1'b0, '0, '0, 1'b0);
    set_beat(1, 1'b0, '0, '0, 1'b0);
    set_tup(0, 1'b0, '0);
    set_tup(1, 1'b0, '0);
    bus.m_bready = 1'b1;
    #12;
    chk_b("rst_bvalid", BW'(bus.m_bvalid), '0);
    chk_b("rst_aready", BW'({bus.s1_aready, bus.s0_aready}), '0);
    do_reset();
    chk_b("rst_state", BW'(dbg_state), BW'(ST_IDLE));
    chk_b("rst_outs", BW'({bus.m_btuser, bus.m_btlast, bus.m_bkeep, bus.m_bdata}), '0);
    chk_b("rst_cnt0", BW'(pkt_cnt0), '0);
    chk_b("rst_cnt1", BW'(pkt_cnt1), '0);
    chk_b("rst_ovf", BW'(tup_ovf), '0);

    // Single 3-beat packet on port 0 with an A5 tuple.
    t = mk_tuple(32'hA5A5_A5A5);
    s = 32'h1111_0000;
    push_pkt(t, s, 3);
    pulse_tuple(0, t);
    send_pkt(0, 3, s, 1'b0, '0, st);
    exp_cnt0 = exp_cnt0 + 1'b1;
    chk_i("single_idle_cycles", st, 1);
    chk_b("single_cnt0", BW'(pkt_cnt0), BW'(exp_cnt0));
    chk_b("single_state_back", BW'(dbg_state), BW'(ST_IDLE));

    // Contention from reset: port0, port1, port0, port1 with one idle cycle each.
    do_reset();
    sa0 = $urandom; sa1 = $urandom; sb0 = $urandom; sb1 = $urandom;
    ta0 = mk_tuple($urandom); ta1 = mk_tuple($urandom);
    tb0 = mk_tuple($urandom); tb1 = mk_tuple($urandom);
    push_pkt(ta0, sa0, 2);
    push_pkt(ta1, sa1, 2);
    push_pkt(tb0, sb0, 2);
    push_pkt(tb1, sb1, 2);
    set_tup(0, 1'b1, ta0);
    set_tup(1, 1'b1, ta1);
    @(posedge clk); #1;
    set_tup(0, 1'b0, '0);
    set_tup(1, 1'b0, '0);
    t_start = cyc;
    t_end   = cyc;
    fork
      begin
        send_pkt(0, 2, sa0, 1'b0, '0, st0);
        pulse_tuple(0, tb0);
        send_pkt(0, 2, sb0, 1'b0, '0, st0);
      end
      begin
        send_pkt(1, 2, sa1, 1'b0, '0, st1);
        pulse_tuple(1, tb1);
        send_pkt(1, 2, sb1, 1'b0, '0, st1);
        t_end = cyc;
      end
    join
    exp_cnt0 = exp_cnt0 + 2'd2;
    exp_cnt1 = exp_cnt1 + 2'd2;
    chk_i("contention_cycles", t_end - t_start, 12);
    chk_b("contention_cnt0", BW'(pkt_cnt0), BW'(exp_cnt0));
    chk_b("contention_cnt1", BW'(pkt_cnt1), BW'(exp_cnt1));

    // Port 1 offers data with no tuple: held off until the tuple lands.
    s = $urandom;
    t = mk_tuple($urandom);
    set_beat(1, 1'b1, mk_data(s, 0), mk_keep(s, 0), 1'b0);
    repeat (10) begin
      @(negedge clk);
      chk_b("no_tuple_aready", BW'(bus.s1_aready), '0);
      chk_b("no_tuple_bvalid", BW'(bus.m_bvalid), '0);
    end
    @(posedge clk); #1;
    push_pkt(t, s, 2);
    pulse_tuple(1, t);
    send_pkt(1, 2, s, 1'b0, '0, st);
    exp_cnt1 = exp_cnt1 + 1'b1;
    chk_i("tuple_grant_latency", st, 1);
    chk_b("no_tuple_cnt1", BW'(pkt_cnt1), BW'(exp_cnt1));

    // Backpressure: ready alternates every cycle over a 4-beat packet.
    s = $urandom;
    t = mk_tuple($urandom);
    push_pkt(t, s, 4);
    pulse_tuple(0, t);
    bus.m_bready = 1'b0;
    t_start = cyc;
    t_end   = cyc;
    st      = 0;
    fork
      begin
        send_pkt(0, 4, s, 1'b0, '0, st);
        t_end = cyc;
      end
      begin
        while (t_end == t_start) begin
          @(posedge clk); #1;
          if (t_end == t_start) bus.m_bready = ~bus.m_bready;
        end
      end
    join
    bus.m_bready = 1'b1;
    @(posedge clk); #1;
    exp_cnt0 = exp_cnt0 + 1'b1;
    chk_i("bp_stalls", st, 4);
    chk_i("bp_cycles", t_end - t_start, 8);
    chk_b("bp_cnt0", BW'(pkt_cnt0), BW'(exp_cnt0));

    // Overflow: a second tuple while port 0 is pending is dropped and flagged.
    s  = $urandom;
    t  = mk_tuple($urandom);
    t2 = mk_tuple($urandom);
    pulse_tuple(0, t);
    pulse_tuple(0, t2);
    chk_b("ovf_set", BW'(tup_ovf), BW'(2'b01));
    push_pkt(t, s, 2);
    send_pkt(0, 2, s, 1'b0, '0, st);
    exp_cnt0 = exp_cnt0 + 1'b1;

    // Tuple coincident with the last-beat handshake on port 1: captured, no overflow.
    s  = $urandom;
    s5 = $urandom;
    t  = mk_tuple($urandom);
    t5 = mk_tuple($urandom);
    pulse_tuple(1, t);
    push_pkt(t, s, 2);
    send_pkt(1, 2, s, 1'b1, t5, st);
    chk_b("eop_tuple_no_ovf", BW'(tup_ovf), BW'(2'b01));
    push_pkt(t5, s5, 1);
    send_pkt(1, 1, s5, 1'b0, '0, st);
    exp_cnt1 = exp_cnt1 + 2'd2;
    chk_b("ovf_cnt0", BW'(pkt_cnt0), BW'(exp_cnt0));
    chk_b("ovf_cnt1", BW'(pkt_cnt1), BW'(exp_cnt1));

    // Asynchronous reset two beats into a four-beat packet.
    s = $urandom;
    t = mk_tuple($urandom);
    pulse_tuple(0, t);
    exp_q.push_back(mk_beat(t, s, 0, 4));
    exp_q.push_back(mk_beat(t, s, 0, 4));
    set_beat(0, 1'b1, mk_data(s, 0), mk_keep(s, 0), 1'b0);
    repeat (3) @(negedge clk);
    #2 rst_n = 1'b0;
    #1;
    chk_i("abort_q_drained", exp_q.size(), 0);
    chk_b("abort_bvalid", BW'(bus.m_bvalid), '0);
    chk_b("abort_aready", BW'({bus.s1_aready, bus.s0_aready}), '0);
    chk_b("abort_outs", BW'({bus.m_btuser, bus.m_btlast, bus.m_bkeep, bus.m_bdata}), '0);
    chk_b("abort_state", BW'(dbg_state), BW'(ST_IDLE));
    chk_b("abort_cnts", BW'({pkt_cnt1, pkt_cnt0}), '0);
    chk_b("abort_ovf", BW'(tup_ovf), '0);
    do_reset();

    // Sixteen single-beat packets wrap the 4-bit counter back to zero.
    for (int i = 0; i < 16; i++) begin
      s = $urandom;
      t = mk_tuple($urandom);
      push_pkt(t, s, 1);
      pulse_tuple(0, t);
      send_pkt(0, 1, s, 1'b0, '0, st);
      exp_cnt0 = exp_cnt0 + 1'b1;
      if (i == 14) chk_b("wrap_cnt0_15", BW'(pkt_cnt0), BW'(exp_cnt0));
    end
    chk_b("wrap_cnt0_0", BW'(pkt_cnt0), BW'(exp_cnt0));
    chk_b("wrap_cnt1", BW'(pkt_cnt1), BW'(exp_cnt1));

    @(posedge clk); #1;
    chk_i("queue_empty", exp_q.size(), 0);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end
endmodule

// File: doc/tuple_pkt_arbiter.md
# tuple_pkt_arbiter

Two-port packet arbiter that shares the single SDNet tuple-output AXIS path between two upstream packet sources. Each source delivers a 256-bit AXIS packet stream plus a one-cycle 128-bit metadata tuple. The block holds each tuple until its packet is granted, arbitrates whole packets round-robin, and presents the winner's beats with the tuple on `tuser` to the downstream AXIS sink.

## Interface
- `DATA_W`, 256, AXIS data width
- `KEEP_W`, 32, AXIS keep width (`DATA_W/8`)
- `TUPLE_W`, 128, tuple / `tuser` width
- `CNT_W`, 32, per-port packet counter width
- `tarb_aclk` in 1: single clock, all logic on rising edge
- `tarb_arst` in 1: reset, asynchronous, active-low
- `s0_avalid`, `s1_avalid` in 1: source N beat valid
- `s0_aready`, `s1_aready` out 1: source N beat ready
- `s0_adata`, `s1_adata` in `DATA_W`: source N beat data
- `s0_akeep`, `s1_akeep` in `KEEP_W`: source N beat keep
- `s0_atlast`, `s1_atlast` in 1: source N last beat
- `s0_tvalid`, `s1_tvalid` in 1: source N tuple strobe, one-cycle pulse
- `s0_tdata`, `s1_tdata` in `TUPLE_W`: source N tuple
- `m_bvalid` out 1, `m_bready` in 1: output handshake
- `m_bdata` out `DATA_W`, `m_bkeep` out `KEEP_W`, `m_btlast` out 1, `m_btuser` out `TUPLE_W`: output beat
- `pkt_cnt0`, `pkt_cnt1` out `CNT_W`: packets forwarded per port
- `tup_ovf` out 2: sticky tuple-overflow flag per port
- `dbg_state` out 2: FSM state

## Operation
- Tuple slot per port: on `sN_tvalid` with slot empty, capture `sN_tdata` and set `pend[N]`.
- `sN_tvalid` with slot full: drop the new tuple, keep the old one, set `tup_ovf[N]`. The flag clears only on reset.
- Request: `req[N] = sN_avalid & pend[N]`. A packet is never granted without its tuple.
- FSM states: IDLE=2'b00, XFER=2'b01. Encoding 2'b1x is unreachable and recovers to IDLE.
- IDLE:
  - All outputs inactive: `m_bvalid`=0, `sN_aready`=0, `m_bdata`/`m_bkeep`/`m_btlast`/`m_btuser`=0.
  - If any `req`, register `grant`: with both requesting, take the port ≠ `last_grant`; otherwise take the sole requester. Go to XFER.
- XFER (combinational mux from the granted port):
  - `m_bvalid=sG_avalid`, `m_bdata=sG_adata`, `m_bkeep=sG_akeep`, `m_btlast=sG_atlast`.
  - `m_btuser=tuple[G]`, stable for the whole packet.
  - `sG_aready=m_bready`. The non-granted port's `aready`=0.
- End of packet: handshake with `sG_atlast`=1. Then clear `pend[G]`, set `last_grant<=G`, `pkt_cntG` +1 (wraps modulo 2^CNT_W), go to IDLE.
- Simultaneous `sG_tvalid` and end-of-packet clear on the same port: the new tuple is captured, `pend` stays 1, and no overflow is flagged.
- `tvalid` for the granted port mid-packet (slot still full): counts as overflow.
- Single-beat packet (`atlast` on the first beat) is legal.

## Timing
- Reset (async assert, sync deassert by the system):
  - state=IDLE, `last_grant`=1 (port 0 wins first tie), `grant`=0.
  - `pend`=0, tuples=0, counters=0, `tup_ovf`=0.
  - All outputs 0.
- Arbitration latency: 1 cycle from `req` high in IDLE to the first beat offered in XFER.
- Throughput: one beat per cycle within a packet. One idle cycle between packets.
- Output path is combinational in XFER: 0-cycle data latency, no buffering.
- Reset asserted mid-packet: immediate abort, pending tuples lost, no partial `tlast` generated.

## Structure
- Package `tarb_pkg`: `DATA_W`/`KEEP_W`/`TUPLE_W` defaults and state encoding constants `ST_IDLE`, `ST_XFER`.
- Sub-module `tuple_slot` (instantiated ×2): tuple register, `pend`, overflow flag, capture/clear logic.
- Top level holds the FSM, round-robin pointer, muxes and counters.

## Test plan
- Single packet: tuple `0xA5…` on port 0, then a 3-beat packet with `m_bready`=1 → one idle cycle, then 3 output beats. `m_btuser=0xA5…` on all beats, `m_btlast` on beat 3, `pkt_cnt0`=1.
- Contention: both ports hold a tuple and a 2-beat packet from reset → order port0, port1, port0, port1. Exactly one idle cycle between packets.
- Missing tuple: port 1 has `avalid`=1 but no tuple for 10 cycles → `s1_aready`=0 and no output. Tuple arrives → grant on the next cycle.
- Backpressure: `m_bready` toggled 1/0 every cycle on a 4-beat packet → data/keep/tuser stable while stalled. 4 beats delivered in 8 cycles.
- Overflow and boundary: second `s0_tvalid` while `pend[0]` → `tup_ovf[0]`=1 and the first tuple is kept. `tvalid` coincident with the `tlast` handshake → captured, no overflow.
- Async reset mid-packet, then counter wrap with `CNT_W`=4: all outputs 0 immediately. Sixteen packets return `pkt_cnt0` to 0.
